ifetch_24: RTL

IFETCH_24 -- requirements
Module: ifetch_24

---
 rtl/ifetch_pkg.sv | 30 +++
 rtl/ifetch_24_if.sv | 17 +
 rtl/fetch_wdog.sv | 33 +++
 rtl/ifetch_24.sv | 108 ++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the ifetch_24 instruction fetcher.
//   - fetch FSM state encoding
//   - byte / instruction widths
//   - default fetch-timeout length
//   - helper mapping a read state to its byte offset from the pc
package ifetch_pkg;

    localparam int BYTE_W          = 8;
    localparam int INSTR_W         = 24;
    localparam int TIMEOUT_CYC_DEF = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_RD_C = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Byte offset of the read issued in a given state. IDLE and DONE present
    // the plain pc on the address bus, so they map to zero.
    function automatic logic [BYTE_W-1:0] rd_offset(input state_e s);
        case (s)
            S_RD_B:  return 8'd1;
            S_RD_C:  return 8'd2;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/ifetch_24_if.sv
// ifetch_24_if: byte-wide memory read bus between the fetcher and memory.
//   mem_addr [7:0] : byte address of the current read (fetcher -> memory)
//   mem_rd         : read request, held until mem_ack  (fetcher -> memory)
//   mem_data [7:0] : read data, valid while mem_ack=1  (memory -> fetcher)
//   mem_ack        : read completion, may be same-cycle (memory -> fetcher)
// Modports: master = fetcher side, slave = memory side.
interface ifetch_24_if;

    logic [ifetch_pkg::BYTE_W-1:0] mem_addr;
    logic                          mem_rd;
    logic [ifetch_pkg::BYTE_W-1:0] mem_data;
    logic                          mem_ack;

    modport master (output mem_addr, output mem_rd, input mem_data, input mem_ack);
    modport slave  (input mem_addr, input mem_rd, output mem_data, output mem_ack);

endinterface

// File: rtl/fetch_wdog.sv
// fetch_wdog: watchdog for a pending memory read.
//   clk, rst  : clock, synchronous active-high reset
//   i_active  : a read is outstanding (fetcher in a RD_* state)
//   i_ack     : the outstanding read completes this cycle
//   o_tmo     : this is the TIMEOUT_CYC-th consecutive un-acked read cycle
// The counter restarts on every ack, whenever no read is outstanding, and
// right after it fires.
module fetch_wdog #(
    parameter int TIMEOUT_CYC = ifetch_pkg::TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_ack,
    output logic o_tmo
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds the number of un-acked cycles already seen, so the current
    // cycle is number r_cnt+1.
    assign o_tmo = i_active && !i_ack && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !i_active || i_ack || o_tmo) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ifetch_24.sv
// ifetch_24: fetches one 24-bit SUBLEQ instruction {A,B,C} as three byte
// reads at pc, pc+1, pc+2 (mod 256), then strobes it into the instruction
// register and advances pc by 3.
//   CLK, RST          : clock, synchronous active-high reset
//   start             : begin a fetch (IDLE only)
//   pc_load, pc_in    : load pc from pc_in (IDLE only; may combine with start)
//   bus               : memory read bus (ifetch_24_if.master)
//   instr_out [23:0]  : last fetched instruction, A=[23:16] B=[15:8] C=[7:0]
//   EN                : one-cycle load strobe, high in DONE
//   busy              : high outside IDLE
//   pc_out [7:0]      : current program counter
//   err               : sticky fetch-timeout flag
// Optional feature: define FETCH_TIMEOUT_EN to abort a read that goes
// TIMEOUT_CYC cycles without ack (sets err, back to IDLE, pc unchanged).
// Without it reads wait forever and err is tied low.
module ifetch_24
    import ifetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               pc_load,
    input  logic [BYTE_W-1:0]  pc_in,
    ifetch_24_if.master        bus,
    output logic [INSTR_W-1:0] instr_out,
    output logic               EN,
    output logic               busy,
    output logic [BYTE_W-1:0]  pc_out,
    output logic               err
);

    state_e                r_state, w_next;
    logic [BYTE_W-1:0]     r_pc;
    logic [2*BYTE_W-1:0]   r_shadow;   // A and B bytes, held until C arrives
    logic [INSTR_W-1:0]    r_instr;
    logic                  w_rd_active;

    assign w_rd_active = (r_state == S_RD_A) || (r_state == S_RD_B) || (r_state == S_RD_C);

`ifdef FETCH_TIMEOUT_EN
    logic w_tmo;
    logic r_err;

    fetch_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk      (CLK),
        .rst      (RST),
        .i_active (w_rd_active),
        .i_ack    (bus.mem_ack),
        .o_tmo    (w_tmo)
    );

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        bus.mem_rd   = w_rd_active;
        bus.mem_addr = r_pc + rd_offset(r_state);
        case (r_state)
            S_IDLE: if (start)       w_next = S_RD_A;
            S_RD_A: if (bus.mem_ack) w_next = S_RD_B;
            S_RD_B: if (bus.mem_ack) w_next = S_RD_C;
            S_RD_C: if (bus.mem_ack) w_next = S_DONE;
            S_DONE:                  w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
`ifdef FETCH_TIMEOUT_EN
        if (w_tmo) w_next = S_IDLE;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_shadow <= '0;
            r_instr  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (pc_load)     r_pc <= pc_in;
                S_RD_A: if (bus.mem_ack) r_shadow[15:8] <= bus.mem_data;
                S_RD_B: if (bus.mem_ack) r_shadow[7:0]  <= bus.mem_data;
                // instr_out only ever changes here, on entry to DONE
                S_RD_C: if (bus.mem_ack) r_instr <= {r_shadow, bus.mem_data};
                S_DONE: r_pc <= r_pc + 8'd3;
                default: ;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST)        r_err <= 1'b0;
        else if (w_tmo) r_err <= 1'b1;
    end
`endif

    assign instr_out = r_instr;
    assign EN        = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign pc_out    = r_pc;

endmodule
